// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  localparam logic [31:0] DEF_RESET_PC    = 32'hBFC0_0000;
  localparam logic [31:0] DEF_EXC_VEC     = 32'hBFC0_0380;
  localparam int unsigned DEF_ACK_TIMEOUT = 16;

  // Wide enough for any ACK_TIMEOUT in 2..255.
  localparam int unsigned TO_CNT_W = 8;

endpackage

// File: rtl/pc_sequencer_add4.sv
// Add_4: PC incrementer producing pc + 4 modulo 2^32.
module Add_4 (
  input  logic [31:0] a_i,
  output logic [31:0] sum_o
);

  assign sum_o = a_i + 32'd4;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, runs the instruction-memory req/ack handshake
// and picks the next PC (sequential, branch/jump target, exception vector).
// Optional exception redirect is enabled by defining PC_SEQ_EXC_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
  parameter int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT
`ifdef PC_SEQ_EXC_EN
  ,
  parameter logic [31:0] EXC_VEC     = DEF_EXC_VEC
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
`ifdef PC_SEQ_EXC_EN
  input  logic        exc_req,
`endif
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_ack,
  input  logic [31:0] inst_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(ACK_TIMEOUT);

  state_e              state_q, state_d;
  logic [31:0]         pc_q, pc_d;
  logic [31:0]         inst_q, inst_d;
  logic                pend_vld_q, pend_vld_d;
  logic [31:0]         pend_tgt_q, pend_tgt_d;
  logic [TO_CNT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
`ifdef PC_SEQ_EXC_EN
  logic                disc_q, disc_d;
`endif

  logic [31:0] pc_inc;
  logic        redir_vld;
  logic [31:0] redir_tgt;
  logic [31:0] next_pc;

  Add_4 u_add4 (
    .a_i  (pc_q),
    .sum_o(pc_inc)
  );

  // Incoming redirect this cycle (jump wins) and the PC the next advance uses;
  // a same-cycle redirect overrides any older pending target.
  always_comb begin
    redir_vld = jump | br_taken;
    redir_tgt = jump ? jump_target : br_target;
    next_pc   = pc_inc;
    if (redir_vld) begin
      next_pc = redir_tgt;
    end else if (pend_vld_q) begin
      next_pc = pend_tgt_q;
    end
  end

  // FSM next-state, PC/instruction update, redirect capture and ack timeout.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
`ifdef PC_SEQ_EXC_EN
    disc_d     = disc_q;
`endif

    if (redir_vld) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = redir_tgt;
    end

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (inst_ack) begin
          cnt_d   = '0;
          inst_d  = inst_rdata;
          state_d = S_OUT;
        end else if (cnt_q != TO_LIMIT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        if (!stall) begin
          pc_d       = next_pc;
          pend_vld_d = 1'b0;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cnt_d == TO_LIMIT) begin
      err_d = 1'b1;
    end

`ifdef PC_SEQ_EXC_EN
    // Exception overrides the normal paths: a word already in flight is still
    // acked by memory but dropped, then the vector is fetched.
    if (exc_req) begin
      pend_vld_d = 1'b0;
      case (state_q)
        S_IDLE: pc_d = EXC_VEC;
        S_REQ: begin
          if (inst_ack) begin
            inst_d  = inst_q;
            pc_d    = EXC_VEC;
            state_d = S_REQ;
            disc_d  = 1'b0;
          end else begin
            disc_d = 1'b1;
          end
        end
        S_OUT: begin
          pc_d    = EXC_VEC;
          state_d = S_REQ;
        end
        default: ;
      endcase
    end else if (disc_q && (state_q == S_REQ) && inst_ack) begin
      inst_d  = inst_q;
      pc_d    = EXC_VEC;
      state_d = S_REQ;
      disc_d  = 1'b0;
    end
`endif
  end

  // State and datapath registers; reset drops the request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inst_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`ifdef PC_SEQ_EXC_EN
      disc_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`ifdef PC_SEQ_EXC_EN
      disc_q     <= disc_d;
`endif
    end
  end

  assign inst_req   = (state_q == S_REQ);
  assign inst_valid = (state_q == S_OUT);
  assign inst_addr  = pc_q;
  assign pc_out     = pc_q;
  assign pc_plus4   = pc_inc;
  assign inst       = inst_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: memory responder with programmable ack delay, an
// event-level fetch model checked every cycle, and directed scenarios.
// Exception scenario is compiled in when PC_SEQ_EXC_EN is defined.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_PC = 32'hBFC0_0380;
  localparam int          TO     = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, br_taken, jump, exc_req;
  logic [31:0] br_target, jump_target;
  logic        inst_req, inst_ack, inst_valid, fetch_err;
  logic [31:0] inst_addr, inst_rdata, inst, pc_out, pc_plus4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .RESET_PC   (RST_PC),
    .ACK_TIMEOUT(TO)
`ifdef PC_SEQ_EXC_EN
    ,
    .EXC_VEC    (EXC_PC)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jump       (jump),
    .jump_target(jump_target),
`ifdef PC_SEQ_EXC_EN
    .exc_req    (exc_req),
`endif
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_ack   (inst_ack),
    .inst_rdata (inst_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc_out     (pc_out),
    .pc_plus4   (pc_plus4),
    .fetch_err  (fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Responder state
  int          ack_delay = 0;
  int          req_age   = 0;
  int          last_len  = 0;
  logic [31:0] acked_q[$];

  // Model state: phase flags, current PC, last delivered word, pending redirect
  bit          m_idle, m_req, m_valid, m_err, m_disc;
  logic [31:0] m_pc, m_inst;
  int          m_wait;
  logic [31:0] m_pend[$];

  // Mid-cycle: compare DUT against model, answer the request, advance model.
  always @(negedge clk) begin
    bit exc_now;
    exc_now = 1'b0;
    if (!rst) begin
      m_idle = 1; m_req = 0; m_valid = 0; m_err = 0; m_disc = 0;
      m_pc = RST_PC; m_inst = '0; m_wait = 0; m_pend.delete();
    end
    chk("inst_req",   {31'b0, inst_req},   {31'b0, m_req});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("pc_out",     pc_out,    m_pc);
    chk("inst_addr",  inst_addr, m_pc);
    chk("pc_plus4",   pc_plus4,  m_pc + 32'd4);
    chk("inst",       inst,      m_inst);
    chk("fetch_err",  {31'b0, fetch_err}, {31'b0, m_err});
    if (!rst) begin
      inst_ack = 1'b0; inst_rdata = '0; req_age = 0;
    end else begin
      if (inst_req && req_age >= ack_delay) begin
        inst_ack   = 1'b1;
        inst_rdata = mem_word(inst_addr);
        acked_q.push_back(inst_addr);
        last_len   = req_age + 1;
        req_age    = 0;
      end else begin
        inst_ack   = 1'b0;
        inst_rdata = 32'hDEAD_BEEF;
        req_age    = inst_req ? req_age + 1 : 0;
      end
`ifdef PC_SEQ_EXC_EN
      exc_now = exc_req;
`endif
      if (exc_now) m_pend.delete();
      else if (jump) begin m_pend.delete(); m_pend.push_back(jump_target); end
      else if (br_taken) begin m_pend.delete(); m_pend.push_back(br_target); end

      if (m_idle) begin
        m_idle = 0; m_req = 1;
        if (exc_now) m_pc = EXC_PC;
      end else if (m_req) begin
        if (inst_ack) begin
          m_wait = 0;
          if (exc_now || m_disc) begin m_disc = 0; m_pc = EXC_PC; end
          else begin m_inst = mem_word(m_pc); m_req = 0; m_valid = 1; end
        end else begin
          m_wait++;
          if (m_wait >= TO) m_err = 1;
          if (exc_now) m_disc = 1;
        end
      end else if (m_valid) begin
        if (exc_now) begin
          m_pc = EXC_PC; m_valid = 0; m_req = 1;
        end else if (!stall) begin
          m_pc = (m_pend.size() != 0) ? m_pend.pop_front() : m_pc + 32'd4;
          m_valid = 0; m_req = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    repeat (3) step();
    acked_q.delete();
    rst = 1'b1;
  endtask

  task automatic wait_acks(input int n, input string name);
    for (int k = 0; k < 300 && acked_q.size() < n; k++) step();
    chk(name, acked_q.size(), n);
  endtask

  task automatic wait_req_addr(input logic [31:0] a, input string name);
    for (int k = 0; k < 300 && !(inst_req && inst_addr === a); k++) step();
    chk(name, inst_addr, a);
  endtask

  task automatic wait_valid(input string name);
    for (int k = 0; k < 300 && !inst_valid; k++) step();
    chk(name, {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int k = 0; k < 300 && !inst_req; k++) step();
    chk(name, {31'b0, inst_req}, 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b0; stall = 0; br_taken = 0; jump = 0; exc_req = 0;
    br_target = '0; jump_target = '0;
    inst_ack = 0; inst_rdata = '0;

    // Reset release: one idle cycle, then sequential fetch with ack tied high
    do_reset();
    chk("idle_no_req", {31'b0, inst_req}, 32'd0);
    step();
    chk("first_req",  {31'b0, inst_req}, 32'd1);
    chk("first_addr", inst_addr, 32'hBFC0_0000);
    wait_acks(3, "seq_acks");
    chk("seq0", acked_q[0], 32'hBFC0_0000);
    chk("seq1", acked_q[1], 32'hBFC0_0004);
    chk("seq2", acked_q[2], 32'hBFC0_0008);

    // Ack delayed by 3 cycles: request held 4 cycles
    ack_delay = 3;
    n = acked_q.size();
    wait_acks(n + 1, "delay_ack");
    chk("delay_len",  last_len,   32'd4);
    chk("delay_addr", acked_q[n], 32'hBFC0_000C);
    ack_delay = 0;

    // Branch during the request of BFC00004: delay slot kept, then target
    do_reset();
    wait_req_addr(32'hBFC0_0004, "br_wait");
    br_target = 32'h0040_0100; br_taken = 1;
    step();
    br_taken = 0;
    wait_acks(3, "br_acks");
    chk("br_slot",   acked_q[1], 32'hBFC0_0004);
    chk("br_target", acked_q[2], 32'h0040_0100);

    // Jump and branch together under a 5-cycle stall: jump wins, word held
    wait_valid("stall_wait");
    stall = 1; jump = 1; jump_target = 32'h0000_1000;
    br_taken = 1; br_target = 32'h0000_2000;
    step();
    jump = 0; br_taken = 0;
    repeat (4) step();
    chk("stall_held", {31'b0, inst_valid}, 32'd1);
    n = acked_q.size();
    stall = 0;
    wait_acks(n + 1, "jump_ack");
    chk("jump_prio", acked_q[n], 32'h0000_1000);

    // Ack timeout: fetch_err rises and stays after the late ack
    ack_delay = 100000;
    repeat (TO + 3) step();
    chk("err_set", {31'b0, fetch_err}, 32'd1);
    ack_delay = 0;
    n = acked_q.size();
    wait_acks(n + 1, "late_ack");
    step(); step();
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);

    // Address wrap: jump to FFFFFFFC in the advance cycle, next fetch is 0
    wait_valid("wrap_wait");
    jump = 1; jump_target = 32'hFFFF_FFFC;
    n = acked_q.size();
    step();
    jump = 0;
    wait_acks(n + 2, "wrap_acks");
    chk("wrap_top", acked_q[n],     32'hFFFF_FFFC);
    chk("wrap_zero", acked_q[n + 1], 32'h0000_0000);

    // Asynchronous reset mid-handshake drops request and the pending redirect
    ack_delay = 5;
    wait_req("async_wait");
    jump = 1; jump_target = 32'h0000_3000;
    step();
    jump = 0;
    #2 rst = 1'b0;
    #1;
    chk("async_req",   {31'b0, inst_req}, 32'd0);
    chk("async_pc",    pc_out, 32'hBFC0_0000);
    chk("async_valid", {31'b0, inst_valid}, 32'd0);
    step(); step();
    acked_q.delete();
    ack_delay = 0;
    rst = 1'b1;
    wait_acks(2, "post_async");
    chk("pend_lost", acked_q[1], 32'hBFC0_0004);

`ifdef PC_SEQ_EXC_EN
    // Exception during a request: acked word discarded, vector fetched next
    ack_delay = 2;
    do_reset();
    wait_req_addr(32'hBFC0_0000, "exc_wait");
    exc_req = 1;
    step();
    exc_req = 0;
    wait_acks(2, "exc_acks");
    chk("exc_vec", acked_q[1], 32'hBFC0_0380);
    wait_valid("exc_valid");
    chk("exc_word", inst, mem_word(32'hBFC0_0380));
    ack_delay = 0;
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
